// File: rtl/root_ext_unit.sv
//==============================================================================
// Module      : root_ext_unit
// Description : Iterative floor sqrt / cbrt / sqrt+cbrt unit with a private
//               shift/add datapath, one root digit per cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module root_ext_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int NS  = (WIDTH + 1) / 2;
  localparam int NC  = (WIDTH + 2) / 3;
  localparam int BW  = WIDTH + 2;
  localparam int SHW = $clog2(3 * WIDTH + 1);

  localparam logic [SHW-1:0] c_SQ_S0   = SHW'(2 * (NS - 1));
  localparam logic [SHW-1:0] c_CB_S0   = SHW'(3 * (NC - 1));
  localparam logic [SHW-1:0] c_SQ_STEP = SHW'(2);
  localparam logic [SHW-1:0] c_CB_STEP = SHW'(3);
  localparam logic [1:0]     c_M_CBRT  = 2'b01;
  localparam logic [1:0]     c_M_SUM   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SQRT = 2'd1,
    S_CBRT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_sq;
  logic [BW-1:0]    r_y2;
  logic [SHW-1:0]   r_sh;

  logic [BW-1:0]    w_y_dbl;
  logic [BW-1:0]    w_y2x;
  logic [BW-1:0]    w_b;
  logic [BW-1:0]    w_xs;
  logic [BW-1:0]    w_y2_nxt;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_x_nxt;
  logic [WIDTH-1:0] w_y_nxt;
  logic             w_take;
  logic             w_last;

  // y and y2 are doubled/quadrupled first; b is the gap to the next root candidate
  assign w_y_dbl  = {1'b0, r_y, 1'b0};
  assign w_y2x    = r_y2 << 2;
  assign w_b      = (r_state == S_CBRT)
                  ? (w_y2x << 1) + w_y2x + (w_y_dbl << 1) + w_y_dbl + BW'(1)
                  : (w_y_dbl << 1) + BW'(1);
  assign w_xs     = {2'b00, r_x >> r_sh};
  assign w_take   = (w_xs >= w_b);
  assign w_sub    = WIDTH'(w_b << r_sh);
  assign w_x_nxt  = w_take ? (r_x - w_sub) : r_x;
  assign w_y_nxt  = {r_y[WIDTH-2:0], w_take};
  assign w_y2_nxt = w_take ? (w_y2x + (w_y_dbl << 1) + BW'(1)) : w_y2x;
  assign w_last   = (r_sh == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = (mode_i == c_M_CBRT) ? S_CBRT : S_SQRT;
        end
      end
      S_SQRT: begin
        busy_o = 1'b1;
        if (w_last) begin
          w_state_nxt = (r_mode == c_M_SUM) ? S_CBRT : S_DONE;
        end
      end
      S_CBRT: begin
        busy_o = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        busy_o      = 1'b1;
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= '0;
      r_b      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_sq     <= '0;
      r_y2     <= '0;
      r_sh     <= '0;
      result_o <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mode <= mode_i;
            r_b    <= b_i;
            r_x    <= a_i;
            r_y    <= '0;
            r_y2   <= '0;
            r_sq   <= '0;
            r_sh   <= (mode_i == c_M_CBRT) ? c_CB_S0 : c_SQ_S0;
          end
        end
        S_SQRT: begin
          r_x  <= w_x_nxt;
          r_y  <= w_y_nxt;
          r_sh <= r_sh - c_SQ_STEP;
          if (w_last) begin
            if (r_mode == c_M_SUM) begin
              // hand over to the cube-root pass on operand b
              r_sq <= w_y_nxt;
              r_x  <= r_b;
              r_y  <= '0;
              r_y2 <= '0;
              r_sh <= c_CB_S0;
            end else begin
              result_o <= w_y_nxt;
            end
          end
        end
        S_CBRT: begin
          r_x  <= w_x_nxt;
          r_y  <= w_y_nxt;
          r_y2 <= w_y2_nxt;
          r_sh <= r_sh - c_CB_STEP;
          if (w_last) begin
            result_o <= w_y_nxt + ((r_mode == c_M_SUM) ? r_sq : '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
